// File: rtl/aes_decryption.sv
// Byte-serial AES-128 decryption core (FIPS-197 inverse cipher).
// A block is 16 key/ciphertext byte pairs in, ten cycles of key expansion,
// eleven inverse rounds, then 16 plaintext bytes out. The first byte on
// either side is bits [127:120], which is FIPS-197 byte 0.
//
// Handshake: load and ready are registered strobes driven by the core.
// key_byte/state_byte are sampled on every rising edge that sees load=1
// (exactly 16 edges, byte 0 first). state_out_byte holds plaintext byte k
// during the k-th cycle with ready=1. The core never waits on the host;
// enable=0 aborts the current block on the next edge.
module aes_decryption (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] key_byte,
    input  logic [7:0] state_byte,
    output logic [7:0] state_out_byte,
    output logic       load,
    output logic       ready
);

    typedef enum logic [2:0] {IDLE, LOAD, KEYEXP, DECRYPT, OUT} stateT;
    // Byte view of a block: element 0 is bits [127:120]
    typedef logic [0:15][7:0] bytesT;

    stateT        state, nextState;
    logic         loadNext, readyNext;
    logic [3:0]   cnt;
    logic [3:0]   rnd;
    logic [127:0] keyReg, stReg;
    logic [127:0] rkStore [0:10];
    logic [127:0] prevKey, rkNew, rkSel, invRound, decNext;
    logic [31:0]  temp, w0, w1, w2, w3;
    bytesT        stBytes;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0)
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] sq, r;
        sq = a;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        logic [15:0] t;
        t = {a, a} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] invSbox(input logic [7:0] a);
        return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Row r of the column-major state rotates right by r columns
    function automatic bytesT invShiftRows(input bytesT a);
        bytesT o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[4*c + r] = a[4*((c - r + 4) % 4) + r];
        return o;
    endfunction

    function automatic bytesT invSubBytes(input bytesT a);
        bytesT o;
        for (int i = 0; i < 16; i++) o[i] = invSbox(a[i]);
        return o;
    endfunction

    function automatic bytesT invMixColumns(input bytesT a);
        bytesT o;
        for (int c = 0; c < 4; c++) begin
            o[4*c]     = gmul(a[4*c], 8'h0e) ^ gmul(a[4*c+1], 8'h0b) ^ gmul(a[4*c+2], 8'h0d) ^ gmul(a[4*c+3], 8'h09);
            o[4*c + 1] = gmul(a[4*c], 8'h09) ^ gmul(a[4*c+1], 8'h0e) ^ gmul(a[4*c+2], 8'h0b) ^ gmul(a[4*c+3], 8'h0d);
            o[4*c + 2] = gmul(a[4*c], 8'h0d) ^ gmul(a[4*c+1], 8'h09) ^ gmul(a[4*c+2], 8'h0e) ^ gmul(a[4*c+3], 8'h0b);
            o[4*c + 3] = gmul(a[4*c], 8'h0b) ^ gmul(a[4*c+1], 8'h0d) ^ gmul(a[4*c+2], 8'h09) ^ gmul(a[4*c+3], 8'h0e);
        end
        return o;
    endfunction

    assign stBytes = stReg;

    // Round datapath: next round key during KEYEXP, next state during DECRYPT
    always_comb begin
        prevKey  = (rnd == 4'd1) ? keyReg : rkStore[rnd - 4'd1];
        temp     = subWord({prevKey[23:0], prevKey[31:24]}) ^ {rcon(rnd), 24'h000000};
        w0       = prevKey[127:96] ^ temp;
        w1       = prevKey[95:64] ^ w0;
        w2       = prevKey[63:32] ^ w1;
        w3       = prevKey[31:0] ^ w2;
        rkNew    = {w0, w1, w2, w3};
        rkSel    = rkStore[4'd10 - rnd];
        invRound = invSubBytes(invShiftRows(stReg)) ^ rkSel;
        if (rnd == 4'd0)
            decNext = stReg ^ rkSel;
        else if (rnd == 4'd10)
            decNext = invRound;
        else
            decNext = invMixColumns(invRound);
    end

    // Next-state and next strobe values; enable=0 always falls back to IDLE
    always_comb begin
        nextState = state;
        loadNext  = load;
        readyNext = ready;
        if (!enable) begin
            nextState = IDLE;
            loadNext  = 1'b0;
            readyNext = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    nextState = LOAD;
                    loadNext  = 1'b1;
                end
                LOAD: if (cnt == 4'd15) begin
                    nextState = KEYEXP;
                    loadNext  = 1'b0;
                end
                KEYEXP: if (rnd == 4'd10) nextState = DECRYPT;
                DECRYPT: if (rnd == 4'd10) begin
                    nextState = OUT;
                    readyNext = 1'b1;
                end
                OUT: if (cnt == 4'd15) begin
                    nextState = IDLE;
                    readyNext = 1'b0;
                end
                default: begin
                    nextState = IDLE;
                    loadNext  = 1'b0;
                    readyNext = 1'b0;
                end
            endcase
        end
    end

    // FSM state and registered strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            load  <= 1'b0;
            ready <= 1'b0;
        end else begin
            state <= nextState;
            load  <= loadNext;
            ready <= readyNext;
        end
    end

    // Byte capture, key expansion, inverse rounds and output byte stepping
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt            <= 4'd0;
            rnd            <= 4'd0;
            keyReg         <= '0;
            stReg          <= '0;
            state_out_byte <= 8'h00;
            for (int i = 0; i < 11; i++) rkStore[i] <= '0;
        end else if (!enable) begin
            cnt <= 4'd0;
            rnd <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 4'd0;
                    rnd <= 4'd0;
                end
                LOAD: begin
                    keyReg <= {keyReg[119:0], key_byte};
                    stReg  <= {stReg[119:0], state_byte};
                    cnt    <= cnt + 4'd1;
                    if (cnt == 4'd15) rnd <= 4'd1;
                end
                KEYEXP: begin
                    rkStore[rnd] <= rkNew;
                    if (rnd == 4'd1) rkStore[0] <= keyReg;
                    rnd <= (rnd == 4'd10) ? 4'd0 : rnd + 4'd1;
                end
                DECRYPT: begin
                    stReg <= decNext;
                    if (rnd == 4'd10) begin
                        rnd            <= 4'd0;
                        cnt            <= 4'd0;
                        state_out_byte <= decNext[127:120];
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                OUT: begin
                    if (cnt == 4'd15) begin
                        cnt <= 4'd0;
                    end else begin
                        state_out_byte <= stBytes[cnt + 4'd1];
                        cnt            <= cnt + 4'd1;
                    end
                end
                default: begin
                    cnt <= 4'd0;
                    rnd <= 4'd0;
                end
            endcase
        end
    end

endmodule
